clk_div_ctrl: RTL and testbench

Reconfiguration controller for the integer clock divider: it shares the divider between two requesters (A and B), each of which may ask for a new division ratio. On each granted request it sequences a safe change: gate the divider, wait, load the new ratio, re-enable, wait, acknowledge. It drives the divider's enable and ratio inputs directly and sits in the `i_ref_clk` domain next to the divider.

---
 rtl/clk_div_ctrl.sv | 101 ++++++++++
 tb/tb_clk_div_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: arbitrates two ratio requesters and sequences gate/load/ungate/ack on the clock divider.
// Define CLK_DIV_CTRL_RR_EN for round-robin arbitration; default is fixed priority (A over B).
module clk_div_ctrl #(
    parameter int RATIO_WIDTH   = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int RESET_RATIO   = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req_a,
    input  logic [RATIO_WIDTH-1:0] i_ratio_a,
    input  logic                   i_req_b,
    input  logic [RATIO_WIDTH-1:0] i_ratio_b,
    output logic                   o_ack_a,
    output logic                   o_ack_b,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_busy,
    output logic                   o_owner
);
    typedef enum logic [2:0] {IDLE, GATE, LOAD, UNGATE, ACK} state_t;

    state_t                 state, state_n;
    logic [3:0]             cnt, cnt_n;
    logic [RATIO_WIDTH-1:0] pend, pend_n, ratio_n;
    logic                   owner_n, win_b, last;

`ifdef CLK_DIV_CTRL_RR_EN
    logic ptr, ptr_n;
    assign win_b = i_req_b & (~i_req_a | ptr);
`else
    assign win_b = i_req_b & ~i_req_a;
`endif

    assign last = cnt == 4'(SETTLE_CYCLES - 1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        owner_n = o_owner;
`ifdef CLK_DIV_CTRL_RR_EN
        ptr_n   = ptr;
`endif
        case (state)
            IDLE: if (i_req_a | i_req_b) begin
                owner_n = win_b;
                pend_n  = win_b ? i_ratio_b : i_ratio_a;
                state_n = (pend_n == o_div_ratio) ? ACK : GATE;
`ifdef CLK_DIV_CTRL_RR_EN
                ptr_n   = ~win_b;
`endif
            end
            GATE: begin
                cnt_n   = last ? 4'd0 : cnt + 4'd1;
                state_n = last ? LOAD : GATE;
            end
            LOAD:   state_n = UNGATE;
            UNGATE: begin
                cnt_n   = last ? 4'd0 : cnt + 4'd1;
                state_n = last ? ACK : UNGATE;
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered from the next state so they align with the state they describe.
        ratio_n = (state_n == LOAD) ? pend : o_div_ratio;
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pend        <= '0;
            o_owner     <= 1'b0;
            o_div_ratio <= RATIO_WIDTH'(RESET_RATIO);
            o_clk_en    <= 1'b1;
            o_busy      <= 1'b0;
            o_ack_a     <= 1'b0;
            o_ack_b     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pend        <= pend_n;
            o_owner     <= owner_n;
            o_div_ratio <= ratio_n;
            o_clk_en    <= !(state_n == GATE || state_n == LOAD);
            o_busy      <= state_n != IDLE;
            o_ack_a     <= state_n == ACK && !owner_n;
            o_ack_b     <= state_n == ACK && owner_n;
        end
    end

`ifdef CLK_DIV_CTRL_RR_EN
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ptr <= 1'b0;
        else
            ptr <= ptr_n;
    end
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: randomized requests, transaction-level model predicts each ack; monitor scores acks and gating invariants.
module tb_clk_div_ctrl;
    localparam int S = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [7:0] ratio_a = '0, ratio_b = '0;
    logic       ack_a, ack_b, clk_en, busy, owner;
    logic [7:0] div_ratio;

    clk_div_ctrl #(.RATIO_WIDTH(8), .SETTLE_CYCLES(S), .RESET_RATIO(2)) dut (
        .i_ref_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_ratio_a(ratio_a),
        .i_req_b(req_b), .i_ratio_b(ratio_b),
        .o_ack_a(ack_a), .o_ack_b(ack_b),
        .o_div_ratio(div_ratio), .o_clk_en(clk_en),
        .o_busy(busy), .o_owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       owner;
        logic [7:0] ratio;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         checks = 0, errors = 0, cyc = 0, run = 0;
    logic [7:0] cur = 8'd2, prev_ratio = 8'd2;
    logic       ptr = 1'b0, prev_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scores every ack against the queue and watches gating invariants.
    always @(negedge clk) begin
        if (!rst_n) begin
            run        = 0;
            prev_en    = 1'b1;
            prev_ratio = 8'd2;
        end else begin
            if (div_ratio != prev_ratio) check("ratio_change_while_gated", int'(clk_en), 0);
            if (!clk_en) run++;
            else if (!prev_en) begin
                check("gate_length", run, S + 1);
                run = 0;
            end
            if (ack_a | ack_b) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack ack_a=%0d ack_b=%0d expected no ack", ack_a, ack_b);
                end else begin
                    e = q.pop_front();
                    check("ack_one_hot", int'(ack_a & ack_b), 0);
                    check("ack_owner", int'(ack_b), int'(e.owner));
                    check("owner", int'(owner), int'(e.owner));
                    check("ack_ratio", int'(div_ratio), int'(e.ratio));
                    check("ack_cycle", cyc, e.cyc);
                    check("busy_at_ack", int'(busy), 1);
                end
            end
            prev_en    = clk_en;
            prev_ratio = div_ratio;
        end
    end

    // One request episode: the model enumerates grants in order, then the driver follows the acks.
    task automatic txn(input bit on_a, input bit on_b, input logic [7:0] ra, input logic [7:0] rb,
                       input bit again, input logic [7:0] ra2);
        bit         pa, pb, ag, w, re;
        logic [7:0] xa, r;
        int         g, n, t, lat;
        pa = on_a; pb = on_b; ag = again; re = again; xa = ra; n = 0;
        @(negedge clk);
        req_a = on_a; req_b = on_b; ratio_a = ra; ratio_b = rb;
        g = cyc + 1;
        while (pa || pb) begin
            w   = pb && (!pa || ptr);
            r   = w ? rb : xa;
            lat = (r == cur) ? 1 : 2 * S + 2;
            q.push_back('{w, r, g + lat - 1});
            g   = g + lat + 1;
            cur = r;
            n++;
`ifdef CLK_DIV_CTRL_RR_EN
            ptr = !w;
`endif
            if (w) pb = 1'b0;
            else begin
                pa = ag;
                xa = ra2;
                ag = 1'b0;
            end
        end
        for (int k = 0; k < n; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(ack_a | ack_b) && t < 60);
            if (!(ack_a | ack_b)) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout waited=%0d cycles expected ack within %0d", t, 2 * S + 2);
                req_a = 1'b0;
                req_b = 1'b0;
                q.delete();
                return;
            end
            if (ack_b) req_b = 1'b0;
            if (ack_a) begin
                req_a = 1'b0;
                if (re) begin
                    re = 1'b0;
                    @(negedge clk);
                    req_a   = 1'b1;
                    ratio_a = ra2;
                end
            end
        end
    endtask

    initial begin
        bit         a, b, ag;
        int         kind;
        logic [7:0] ra, rb, ra2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_clk_en", int'(clk_en), 1);
            check("rst_ratio", int'(div_ratio), 2);
            check("rst_busy", int'(busy), 0);
            check("rst_owner", int'(owner), 0);
            check("rst_ack", int'(ack_a | ack_b), 0);
        end
        txn(1, 0, 8'd2, 8'd0, 0, 8'd0);
        txn(1, 0, 8'd5, 8'd0, 0, 8'd0);
        txn(1, 1, 8'd3, 8'd7, 0, 8'd0);
        txn(1, 1, 8'd4, 8'd9, 1, 8'd6);
        txn(0, 1, 8'd0, 8'd0, 0, 8'd0);
        txn(0, 1, 8'd0, 8'd1, 0, 8'd0);
        // Reset while gated: outputs return at once and the request is dropped.
        @(negedge clk);
        req_a   = 1'b1;
        ratio_a = cur + 8'd1;
        repeat (3) @(negedge clk);
        check("pre_rst_gated", int'(clk_en), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_clk_en", int'(clk_en), 1);
        check("midrst_ratio", int'(div_ratio), 2);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ack", int'(ack_a | ack_b), 0);
        req_a = 1'b0;
        cur   = 8'd2;
        ptr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(1, 3);
            a    = kind[0];
            b    = kind[1];
            ra   = ($urandom_range(0, 3) == 0) ? cur : 8'($urandom_range(0, 255));
            rb   = ($urandom_range(0, 3) == 0) ? cur : 8'($urandom_range(0, 255));
            ag   = a && b && ($urandom_range(0, 3) == 0);
            ra2  = 8'($urandom_range(0, 255));
            txn(a, b, ra, rb, ag, ra2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
